pipelined_hybrid_adder: RTL
===========================

PIPELINED_HYBRID_ADDER -- requirements
Module: pipelined_hybrid_adder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-003 Parameter BLOCK, default 4: CLA block width; pipeline depth N = WIDTH/BLOCK.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port in_valid  input  1  operand set presented.
REQ-007 Port in_ready  output  1  block accepts operands this cycle.
REQ-008 Port A  input  WIDTH  first operand.
REQ-009 Port B  input  WIDTH  second operand.
REQ-010 Port Cin  input  1  carry-in (add mode only).
REQ-011 Port sub  input  1  0 = A+B+Cin; 1 = A-B, computed as A+~B+1, with Cin ignored.
REQ-012 Port out_valid  output  1  result valid.
REQ-013 Port out_ready  input  1  consumer accepts the result.
REQ-014 Port Sum  output  WIDTH  result.
REQ-015 Port Cout  output  1  carry-out of the MSB; in sub mode 1 means no borrow.
REQ-016 Port Ovf  output  1  two's-complement signed overflow.
REQ-017 Port Zero  output  1  Sum equals 0.

Function
REQ-018 An operand set SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-019 Stage k (k = 0..N-1) SHALL add bit-slice k of A and B in one BLOCK-bit CLA, using the registered carry from stage k-1 (stage 0: Cin, or 1 when sub=1).
REQ-020 Unprocessed upper operand slices and completed lower sum slices SHALL travel in skew registers alongside each stage, together with sub and the operand sign bits.
REQ-021 The latency SHALL be exactly N cycles: out_valid rises N edges after acceptance when out_ready is held at 1.
REQ-022 The throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-023 The pipeline SHALL advance when advance = !out_valid || out_ready; otherwise all stages hold.
REQ-024 in_ready SHALL equal advance.
REQ-025 Results SHALL emerge in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-026 Bubbles SHALL propagate as invalid slots, and advance SHALL let new data fill them.
REQ-027 Ovf SHALL equal (sA == sB') && (sSum != sA), where sB' is the sign bit of B in add mode and of ~B in sub mode.
REQ-028 Zero, Ovf, Sum and Cout SHALL be registered outputs, stable while out_valid=1 and out_ready=0.
REQ-029 Sum/Cout SHALL be bit-exact to the (WIDTH+1)-bit result of A+B+Cin, or A+~B+1 in sub mode.
REQ-030 A WIDTH that is not a multiple of BLOCK, or BLOCK < 1, SHALL cause an elaboration error.

Reset
REQ-031 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, Sum, Cout, Ovf and Zero to 0 without waiting for a clock edge; in_ready SHALL read 1.
REQ-032 A reset mid-operation SHALL discard all in-flight operations, and no stale result SHALL appear after deassertion.
REQ-033 The first acceptance after deassertion SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-034 The default WIDTH/BLOCK constants and the flag-bit ordering SHALL be placed in a shared package named adder_pkg.
REQ-035 One sub-module cla_block, parametrised on BLOCK (inputs a, b, cin; outputs s, cout; generate/propagate lookahead), SHALL be instantiated N times.

Verification
REQ-036 Add, WIDTH=16, BLOCK=4, A=0x00FF, B=0x0001, Cin=0 -> Sum=0x0100, Cout=0, Ovf=0, Zero=0, out_valid exactly 4 cycles after acceptance.
REQ-037 Add, A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Zero=1, Ovf=0.
REQ-038 Add, A=0x7FFF, B=0x0000, Cin=1 -> Sum=0x8000, Ovf=1, Cout=0.
REQ-039 Sub, A=0x8000, B=0x0001 -> Sum=0x7FFF, Cout=1, Ovf=1; sub A=0x0003, B=0x0005 -> Sum=0xFFFE, Cout=0.
REQ-040 Six back-to-back operations with out_ready=0 for cycles 5-7 -> in_ready=0 during the stall, all six results in order, each held stable while stalled.
REQ-041 rst_n pulsed low with 3 operations in flight -> out_valid=0 immediately, and no result emerges until a new operation has completed its N-cycle latency.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: default sizing, flag-bit layout and the shared
// signed-overflow rule for the pipelined hybrid adder.
package adder_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_BLOCK = 4;

    localparam int FLAG_W   = 3;
    localparam int FLG_COUT = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_ZERO = 2;

    // Like-signed operands whose result sign differs have overflowed.
    function automatic logic ovf_calc(
        input logic sa,
        input logic sb,
        input logic ss
    );
        return (sa == sb) && (ss != sa);
    endfunction

endpackage

// File: rtl/cla_block.sv
// cla_block: BLOCK-bit carry-lookahead adder slice; every carry is
// formed directly from generate/propagate terms and the slice carry-in.
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             pp;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end

    assign s    = p ^ c[BLOCK-1:0];
    assign cout = c[BLOCK];

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// pipelined_hybrid_adder: WIDTH/BLOCK-stage carry-pipelined adder with
// skewed operand/sum registers and a valid/ready stall-all handshake.
module pipelined_hybrid_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int BLOCK = ADD_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int  BLK_SAFE = (BLOCK < 1) ? 1 : BLOCK;
    localparam int  N        = WIDTH / BLK_SAFE;
    localparam bit  BAD_CFG  = (BLOCK < 1) || ((WIDTH % BLK_SAFE) != 0);

    if (BAD_CFG) begin : g_bad_cfg
        $error("pipelined_hybrid_adder: WIDTH must be a multiple of BLOCK >= 1");
    end

    // Rank k holds an operation whose slice k is next to be added.
    logic [N-1:0]            vld_q;
    logic [N-1:0][WIDTH-1:0] a_q;
    logic [N-1:0][WIDTH-1:0] b_q;
    logic [N-1:0][WIDTH-1:0] s_q;
    logic [N-1:0][WIDTH-1:0] s_d;
    logic [N-1:0]            c_q;
    logic [N-1:0]            sub_q;
    logic [N-1:0]            sa_q;
    logic [N-1:0]            sb_q;

    logic [N-1:0][BLOCK-1:0] blk_s;
    logic [N-1:0]            blk_c;

    logic                    ov_q;
    logic [WIDTH-1:0]        sum_q;
    logic [WIDTH-1:0]        sum_d;
    logic [FLAG_W-1:0]       flg_q;
    logic [FLAG_W-1:0]       flg_d;
    logic                    adv;

    assign adv = !ov_q || out_ready;

    for (genvar k = 0; k < N; k++) begin : g_stage
        cla_block #(
            .BLOCK(BLOCK)
        ) u_cla (
            .a   (a_q[k][k*BLOCK +: BLOCK]),
            .b   (b_q[k][k*BLOCK +: BLOCK] ^ {BLOCK{sub_q[k]}}),
            .cin (c_q[k]),
            .s   (blk_s[k]),
            .cout(blk_c[k])
        );
    end

    always_comb begin
        s_d = s_q;
        for (int k = 0; k < N; k++) begin
            s_d[k][k*BLOCK +: BLOCK] = blk_s[k];
        end
        sum_d           = s_d[N-1];
        flg_d           = '0;
        flg_d[FLG_COUT] = blk_c[N-1];
        flg_d[FLG_OVF]  = ovf_calc(sa_q[N-1],
                                   sb_q[N-1] ^ sub_q[N-1],
                                   sum_d[WIDTH-1]);
        flg_d[FLG_ZERO] = (sum_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            sub_q <= '0;
            sa_q  <= '0;
            sb_q  <= '0;
            ov_q  <= 1'b0;
            sum_q <= '0;
            flg_q <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            a_q[0]   <= A;
            b_q[0]   <= B;
            s_q[0]   <= '0;
            c_q[0]   <= sub | Cin;
            sub_q[0] <= sub;
            sa_q[0]  <= A[WIDTH-1];
            sb_q[0]  <= B[WIDTH-1];
            for (int k = 1; k < N; k++) begin
                vld_q[k] <= vld_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                s_q[k]   <= s_d[k-1];
                c_q[k]   <= blk_c[k-1];
                sub_q[k] <= sub_q[k-1];
                sa_q[k]  <= sa_q[k-1];
                sb_q[k]  <= sb_q[k-1];
            end
            ov_q  <= vld_q[N-1];
            sum_q <= sum_d;
            flg_q <= flg_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = ov_q;
    assign Sum       = sum_q;
    assign Cout      = flg_q[FLG_COUT];
    assign Ovf       = flg_q[FLG_OVF];
    assign Zero      = flg_q[FLG_ZERO];

endmodule
